// File: rtl/cart_bus_ctrl_if.sv
// Cartridge bus controller signal bundle: CPU port, DMA port and cartridge pins.
// master = requesters and pin model side, slave = cart_bus_ctrl.
interface cart_bus_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [15:0] cart_address;
  logic [7:0]  cart_data_in;
  logic [7:0]  cart_data_out;
  logic        cart_data_oe;
  logic        cart_r_enable_l;
  logic        cart_w_enable_l;
  logic        cart_cs_sram_l;
  logic        cart_reset_l;
  logic        busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_addr, cart_data_in,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata, cart_address, cart_data_out,
    input  cart_data_oe, cart_r_enable_l, cart_w_enable_l, cart_cs_sram_l, cart_reset_l, busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_addr, cart_data_in,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata, cart_address, cart_data_out,
    output cart_data_oe, cart_r_enable_l, cart_w_enable_l, cart_cs_sram_l, cart_reset_l, busy
  );
endinterface

// File: rtl/cart_bus_ctrl.sv
// Arbitrates CPU and DMA onto the cartridge bus and runs timed SETUP/STROBE/HOLD cycles.
// Optional CART_ARB_RR_EN selects round-robin arbitration instead of DMA-first priority.
module cart_bus_ctrl #(
  parameter int unsigned ADDR_SETUP    = 1,
  parameter int unsigned STROBE_CYCLES = 3,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input logic           clock,
  input logic           reset_l,
  cart_bus_ctrl_if.slave bus
);

  localparam logic [3:0] SetupLoad  = 4'(ADDR_SETUP - 1);
  localparam logic [3:0] StrobeLoad = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HoldLoad   = 4'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        gnt_dma_q, gnt_dma_d;

  logic        cpu_ack_q, cpu_ack_d;
  logic        dma_ack_q, dma_ack_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  dma_rdata_q, dma_rdata_d;
  logic [15:0] cart_address_q, cart_address_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;
  logic        rd_l_q, rd_l_d;
  logic        wr_l_q, wr_l_d;
  logic        cs_l_q, cs_l_d;
  logic        cart_reset_l_q;
  logic        busy_q, busy_d;

  logic any_req;
  logic grant_dma;
  logic sample_rd;
  logic active_d;

  assign any_req = bus.cpu_req | bus.dma_req;

`ifdef CART_ARB_RR_EN
  // last_dma_q = 1 when DMA won the most recent grant; ties go to the other requester.
  logic last_dma_q, last_dma_d;

  always_comb begin
    if (bus.cpu_req && bus.dma_req) begin
      grant_dma = ~last_dma_q;
    end else begin
      grant_dma = bus.dma_req;
    end
    last_dma_d = (state_q == StIdle && any_req) ? grant_dma : last_dma_q;
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      last_dma_q <= 1'b1;
    end else begin
      last_dma_q <= last_dma_d;
    end
  end
`else
  assign grant_dma = bus.dma_req;
`endif

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q        <= StIdle;
      cnt_q          <= 4'd0;
      addr_q         <= 16'h0000;
      we_q           <= 1'b0;
      wdata_q        <= 8'h00;
      gnt_dma_q      <= 1'b0;
      cpu_ack_q      <= 1'b0;
      dma_ack_q      <= 1'b0;
      cpu_rdata_q    <= 8'h00;
      dma_rdata_q    <= 8'h00;
      cart_address_q <= 16'h0000;
      data_out_q     <= 8'h00;
      data_oe_q      <= 1'b0;
      rd_l_q         <= 1'b1;
      wr_l_q         <= 1'b1;
      cs_l_q         <= 1'b1;
      cart_reset_l_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      wdata_q        <= wdata_d;
      gnt_dma_q      <= gnt_dma_d;
      cpu_ack_q      <= cpu_ack_d;
      dma_ack_q      <= dma_ack_d;
      cpu_rdata_q    <= cpu_rdata_d;
      dma_rdata_q    <= dma_rdata_d;
      cart_address_q <= cart_address_d;
      data_out_q     <= data_out_d;
      data_oe_q      <= data_oe_d;
      rd_l_q         <= rd_l_d;
      wr_l_q         <= wr_l_d;
      cs_l_q         <= cs_l_d;
      cart_reset_l_q <= 1'b1;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    gnt_dma_d = gnt_dma_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d   = StSetup;
          cnt_d     = SetupLoad;
          addr_d    = grant_dma ? bus.dma_addr : bus.cpu_addr;
          we_d      = ~grant_dma & bus.cpu_we;
          wdata_d   = bus.cpu_wdata;
          gnt_dma_d = grant_dma;
        end
      end
      StSetup: begin
        if (cnt_q == 4'd0) begin
          state_d = StStrobe;
          cnt_d   = StrobeLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are derived from the next state so that every pin comes straight from a flop.
  always_comb begin
    active_d       = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
    sample_rd      = (state_q == StStrobe) && (cnt_q == 4'd0) && !we_q;
    cart_address_d = active_d ? addr_d : cart_address_q;
    cs_l_d         = ~(active_d && (addr_d[15:13] == 3'b101));
    data_oe_d      = active_d && we_d;
    data_out_d     = (active_d && we_d) ? wdata_d : data_out_q;
    rd_l_d         = ~((state_d == StStrobe) && !we_d);
    wr_l_d         = ~((state_d == StStrobe) && we_d);
    cpu_ack_d      = (state_d == StDone) && !gnt_dma_d;
    dma_ack_d      = (state_d == StDone) && gnt_dma_d;
    cpu_rdata_d    = (sample_rd && !gnt_dma_q) ? bus.cart_data_in : cpu_rdata_q;
    dma_rdata_d    = (sample_rd && gnt_dma_q) ? bus.cart_data_in : dma_rdata_q;
    busy_d         = (state_d != StIdle);
  end

  assign bus.cpu_ack         = cpu_ack_q;
  assign bus.dma_ack         = dma_ack_q;
  assign bus.cpu_rdata       = cpu_rdata_q;
  assign bus.dma_rdata       = dma_rdata_q;
  assign bus.cart_address    = cart_address_q;
  assign bus.cart_data_out   = data_out_q;
  assign bus.cart_data_oe    = data_oe_q;
  assign bus.cart_r_enable_l = rd_l_q;
  assign bus.cart_w_enable_l = wr_l_q;
  assign bus.cart_cs_sram_l  = cs_l_q;
  assign bus.cart_reset_l    = cart_reset_l_q;
  assign bus.busy            = busy_q;

endmodule

// File: doc/cart_bus_ctrl.md
Name: cart_bus_ctrl

Overview:
Sequencer and arbiter for the external Game Boy cartridge bus: address, strobes, SRAM chip select, data and reset. Two requesters share the bus: the CPU memory port (read/write) and the OAM/HDMA DMA engine (read-only). The block arbitrates between them and runs each access as a timed SETUP/STROBE/HOLD cycle with configurable lengths. It returns read data and a one-cycle ack, and sits between the memory map decoder and the header pin-mapping layer.

Parameters:
ADDR_SETUP, 1, cycles address/CS are stable before a strobe (legal 1..15)
STROBE_CYCLES, 3, cycles RD_L/WR_L are held low (legal 1..15)
HOLD_CYCLES, 1, cycles address/data are held after strobe release (legal 1..15)

Ports:
clock  in  1  system clock, all logic on rising edge
reset_l  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  16  CPU byte address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  read data, valid with cpu_ack and held until next CPU read
dma_req  in  1  DMA read request, held until dma_ack
dma_addr  in  16  DMA byte address
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  8  read data, valid with dma_ack and held until next DMA read
cart_address  out  16  cartridge address bus
cart_data_in  in  8  cartridge data from pins
cart_data_out  out  8  data driven to pins on writes
cart_data_oe  out  1  1 = FPGA drives data pins
cart_r_enable_l  out  1  RD strobe, active low
cart_w_enable_l  out  1  WR strobe, active low
cart_cs_sram_l  out  1  SRAM chip select, active low
cart_reset_l  out  1  cartridge reset, active low
busy  out  1  1 when state != IDLE

Behaviour:
- All outputs are registered.
- Reset values: cpu_ack=0, dma_ack=0, cpu_rdata=0x00, dma_rdata=0x00, cart_address=0x0000, cart_data_out=0x00, cart_data_oe=0, cart_r_enable_l=1, cart_w_enable_l=1, cart_cs_sram_l=1, cart_reset_l=0, busy=0.
- cart_reset_l goes to 1 on the first rising edge after reset_l deasserts and stays 1.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE. One 4-bit down-counter is loaded at each phase entry.
- IDLE: arbitrate on a rising edge where any req=1. The winner's addr/we/wdata are latched (DMA forces we=0). Go to SETUP and load ADDR_SETUP-1. With no request, stay in IDLE; cart_address keeps its last value.
- SETUP: cart_address = latched addr. cart_cs_sram_l=0 iff addr in 0xA000..0xBFFF. Strobes stay high. For writes, cart_data_out = wdata and cart_data_oe=1 from SETUP onward. At count 0, go to STROBE and load STROBE_CYCLES-1.
- STROBE: a read drives cart_r_enable_l=0; a write drives cart_w_enable_l=0. On the edge leaving the last STROBE cycle, a read samples cart_data_in into the winner's rdata register. Then go to HOLD and load HOLD_CYCLES-1.
- HOLD: both strobes are 1. Address, CS and write data/oe are held. At count 0, go to DONE.
- DONE: the winner's ack=1 for exactly this cycle. cart_cs_sram_l=1, cart_data_oe=0. No arbitration in this cycle, so the requester can drop req on ack. Next state is IDLE.
- Latency: the ack cycle begins ADDR_SETUP+STROBE_CYCLES+HOLD_CYCLES edges after the granting edge (5 with defaults). A continuously held request is re-granted two edges after the previous ack.
- Arbitration is fixed priority: DMA wins over CPU when both requests are present in IDLE. The loser waits; its request must stay asserted and is not dropped.
- Read and write strobes are never both low. cart_data_oe is never 1 during a read.
- Reset mid-operation: every output returns to its reset value immediately. No ack is issued, and the aborted requester must re-present its request.
- A request that deasserts before ack while granted is a protocol violation. The access still completes and ack is still pulsed.

Optional Feature:
Macro CART_ARB_RR_EN.
- Defined: round-robin arbitration. A last_grant flag records which requester won last; on a simultaneous request the requester that did not win last is granted. last_grant resets to DMA, so the first tie goes to the CPU. A lone requester is always granted.
- Undefined: fixed DMA-over-CPU priority as above, and no last_grant register exists.

Test Plan:
- CPU read, addr 0x0147, cart_data_in=0x03: cart_address=0x0147, cart_cs_sram_l=1, cart_r_enable_l low for exactly 3 cycles, cpu_ack 5 edges after grant, cpu_rdata=0x03, cart_data_oe=0 throughout.
- CPU write, addr 0xA010, data 0x5A: cart_cs_sram_l=0 for 5 cycles (SETUP+STROBE+HOLD), cart_w_enable_l low for 3 cycles, cart_data_oe=1 and cart_data_out=0x5A across SETUP..HOLD, cart_r_enable_l=1 throughout.
- cpu_req and dma_req raised on the same edge (dma_addr 0xC000 is out of range, so substitute 0x4000 with data 0x77): DMA served first, dma_rdata=0x77. CPU granted two edges after dma_ack. With CART_ARB_RR_EN, the CPU is served first instead.
- Back-to-back CPU reads held continuously with STROBE_CYCLES=1, ADDR_SETUP=2, HOLD_CYCLES=2: ack period is 7 cycles and the strobe is low for 1 cycle per access.
- reset_l pulsed low during the 2nd STROBE cycle of a write: cart_w_enable_l=1, cart_data_oe=0, cart_reset_l=0 immediately, no cpu_ack. After release, cart_reset_l=1 one edge later and the re-issued write completes normally.
- Idle after reset with no requests: busy=0, all strobes and CS high, cart_address=0x0000, and no acks for 100 cycles.
